// File: rtl/ofifo_pkg.sv
// Shared definitions for the output FIFO bank: width helper and default geometry.
package ofifo_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    localparam int unsigned default_col   = 8;
    localparam int unsigned default_bw    = 16;
    localparam int unsigned default_depth = 64;
    localparam int unsigned default_ptr_w = clog2(default_depth);
    localparam int unsigned default_cnt_w = clog2(default_depth + 1);

endpackage

// File: rtl/ofifo_col.sv
// Single-column circular buffer; push is dropped when full, pop is gated by the caller.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int unsigned bw        = default_bw,
    parameter int unsigned depth     = default_depth,
    parameter int unsigned af_margin = 2,
    localparam int unsigned ptr_w    = clog2(depth),
    localparam int unsigned cnt_w    = clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [bw-1:0]    din,
    output logic [bw-1:0]    dout,
    output logic [cnt_w-1:0] cnt,
    output logic             empty,
    output logic             full,
    output logic             afull
);

    logic [bw-1:0]    mem [depth];
    logic [ptr_w-1:0] wptr;
    logic [ptr_w-1:0] rptr;
    logic             push_ok;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never frees room.
    assign push_ok = push & ~full;
    assign full    = (cnt == cnt_w'(depth));
    assign empty   = (cnt == '0);
    assign afull   = (cnt >= cnt_w'(depth - af_margin));
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + ptr_w'(1);
            end
            if (pop) begin
                rptr <= rptr + ptr_w'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + cnt_w'(1);
                2'b01:   cnt <= cnt - cnt_w'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ofifo_row_sync.sv
// Output FIFO bank: per-column independent writes, whole-row registered pops.
module ofifo_row_sync
    import ofifo_pkg::*;
#(
    parameter int unsigned col       = default_col,
    parameter int unsigned bw        = default_bw,
    parameter int unsigned depth     = default_depth,
    parameter int unsigned af_margin = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    input  logic              clr_err,
    output logic [col*bw-1:0] out,
    output logic              o_out_vld,
    output logic              o_valid,
    output logic              o_ready,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned cnt_w = clog2(depth + 1);

    logic [col-1:0]       empty_v;
    logic [col-1:0]       full_v;
    logic [col-1:0]       afull_v;
    logic [col*bw-1:0]    dout_row;
    logic [col*cnt_w-1:0] cnt_v;
    logic                 pop;
    logic                 unused_cnt;

    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_col #(
            .bw        (bw),
            .depth     (depth),
            .af_margin (af_margin)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .push  (wr[i]),
            .pop   (pop),
            .din   (in[bw*i +: bw]),
            .dout  (dout_row[bw*i +: bw]),
            .cnt   (cnt_v[cnt_w*i +: cnt_w]),
            .empty (empty_v[i]),
            .full  (full_v[i]),
            .afull (afull_v[i])
        );
    end

    // Row-level status reductions and pop gating.
    assign o_valid       = ~|empty_v;
    assign o_full        = |full_v;
    assign o_ready       = ~o_full;
    assign o_almost_full = |afull_v;
    assign pop           = rd & o_valid;
    assign unused_cnt    = ^cnt_v;

    // Output register and sticky errors; a new error wins over clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            out         <= '0;
            o_out_vld   <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_out_vld <= pop;
            if (pop) begin
                out <= dout_row;
            end
            o_overflow  <= (o_overflow & ~clr_err) | (|(wr & full_v));
            o_underflow <= (o_underflow & ~clr_err) | (rd & ~o_valid);
        end
    end

endmodule

// File: tb/tb_ofifo_row_sync.sv
// Directed self-checking bench for ofifo_row_sync with hand-computed expectations.
module tb_ofifo_row_sync;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int CW    = 7;

    logic              clk;
    logic              reset;
    logic [COL*BW-1:0] in;
    logic [COL-1:0]    wr;
    logic              rd;
    logic              clr_err;
    logic [COL*BW-1:0] out;
    logic              o_out_vld;
    logic              o_valid;
    logic              o_ready;
    logic              o_full;
    logic              o_almost_full;
    logic              o_overflow;
    logic              o_underflow;

    int checks;
    int failures;

    ofifo_row_sync #(
        .col       (COL),
        .bw        (BW),
        .depth     (DEPTH),
        .af_margin (2)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .in            (in),
        .wr            (wr),
        .rd            (rd),
        .clr_err       (clr_err),
        .out           (out),
        .o_out_vld     (o_out_vld),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COL*BW-1:0] row_pat(input int r);
        logic [COL*BW-1:0] v;
        for (int i = 0; i < COL; i++) v[BW*i +: BW] = 16'((r << 4) | i);
        return v;
    endfunction

    function automatic logic [COL*BW-1:0] row_base(input logic [15:0] base);
        logic [COL*BW-1:0] v;
        for (int i = 0; i < COL; i++) v[BW*i +: BW] = base + 16'(i);
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1; wr = '0; rd = 1'b0; clr_err = 1'b0; in = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out !== '0) begin failures++; $display("FAIL reset_out got=%h want=0", out); end
        checks++; if (o_out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b want=0", o_out_vld); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", o_full); end
        checks++; if (o_almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b want=0", o_almost_full); end
        checks++; if ({o_overflow, o_underflow} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%b want=00", {o_overflow, o_underflow}); end
    endtask

    task automatic test_single_row();
        logic [COL*BW-1:0] exp_row;
        do_reset();
        exp_row = row_base(16'h0A00);
        in = exp_row; wr = 8'hFF;
        tick();
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid_before got=%b want=1", o_valid); end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (o_out_vld !== 1'b1) begin failures++; $display("FAIL single_out_vld got=%b want=1", o_out_vld); end
        checks++; if (out !== exp_row) begin failures++; $display("FAIL single_out got=%h want=%h", out, exp_row); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_valid_after got=%b want=0", o_valid); end
        tick();
        checks++; if (o_out_vld !== 1'b0) begin failures++; $display("FAIL single_vld_drop got=%b want=0", o_out_vld); end
        checks++; if (out !== exp_row) begin failures++; $display("FAIL single_out_hold got=%h want=%h", out, exp_row); end
    endtask

    task automatic test_staggered();
        logic [COL*BW-1:0] exp_row;
        do_reset();
        exp_row = row_base(16'h1100);
        in = exp_row;
        for (int k = 0; k < COL; k++) begin
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stagger_valid_%0d got=%b want=0", k, o_valid); end
            wr = COL'(1) << k;
            tick();
        end
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL stagger_valid_final got=%b want=1", o_valid); end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (out !== exp_row) begin failures++; $display("FAIL stagger_out got=%h want=%h", out, exp_row); end
    endtask

    task automatic test_full_overflow();
        do_reset();
        wr = 8'h08;
        for (int n = 1; n <= DEPTH; n++) begin
            in = '0;
            in[BW*3 +: BW] = 16'(16'h3000 + n);
            tick();
            checks++; if (o_almost_full !== (n >= DEPTH - 2)) begin failures++; $display("FAIL afull_after_%0d got=%b want=%b", n, o_almost_full, (n >= DEPTH - 2)); end
            checks++; if (o_full !== (n == DEPTH)) begin failures++; $display("FAIL full_after_%0d got=%b want=%b", n, o_full, (n == DEPTH)); end
        end
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", o_ready); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b want=0", o_overflow); end
        tick();
        wr = '0;
        checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", o_overflow); end
        checks++; if (u_dut.cnt_v[3*CW +: CW] !== 7'd64) begin failures++; $display("FAIL ovf_cnt3 got=%0d want=64", u_dut.cnt_v[3*CW +: CW]); end
        checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b want=1", o_full); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", o_overflow); end
    endtask

    task automatic test_underflow();
        logic [COL*BW-1:0] exp_row;
        do_reset();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (o_underflow !== 1'b1) begin failures++; $display("FAIL unf_set got=%b want=1", o_underflow); end
        checks++; if (o_out_vld !== 1'b0) begin failures++; $display("FAIL unf_vld got=%b want=0", o_out_vld); end
        clr_err = 1'b1;
        tick();
        checks++; if (o_underflow !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b want=0", o_underflow); end
        rd = 1'b1;
        tick();
        rd = 1'b0; clr_err = 1'b0;
        checks++; if (o_underflow !== 1'b1) begin failures++; $display("FAIL unf_set_wins got=%b want=1", o_underflow); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_row = row_base(16'h5500);
        in = exp_row; wr = 8'hFF;
        tick();
        wr = '0; rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (out !== exp_row) begin failures++; $display("FAIL unf_ptr_intact got=%h want=%h", out, exp_row); end
        checks++; if (o_underflow !== 1'b0) begin failures++; $display("FAIL unf_stays_clear got=%b want=0", o_underflow); end
    endtask

    task automatic test_back_to_back();
        int vld_run;
        do_reset();
        wr = 8'hFF;
        for (int r = 0; r < DEPTH; r++) begin
            in = row_pat(r);
            tick();
        end
        wr = '0;
        checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b want=1", o_full); end
        vld_run = 0;
        // First pop alone: writes into a full bank would be dropped.
        for (int k = 0; k < DEPTH; k++) begin
            rd = 1'b1;
            wr = (k == 0) ? 8'h00 : 8'hFF;
            in = row_pat(DEPTH - 1 + k);
            tick();
            if (o_out_vld === 1'b1) vld_run++;
            checks++; if (out !== row_pat(k)) begin failures++; $display("FAIL b2b_row_%0d got=%h want=%h", k, out, row_pat(k)); end
        end
        wr = '0;
        for (int k = DEPTH; k < 2 * DEPTH - 1; k++) begin
            tick();
            if (o_out_vld === 1'b1) vld_run++;
            checks++; if (out !== row_pat(k)) begin failures++; $display("FAIL b2b_wrap_row_%0d got=%h want=%h", k, out, row_pat(k)); end
        end
        rd = 1'b0;
        checks++; if (vld_run !== 2 * DEPTH - 1) begin failures++; $display("FAIL b2b_vld_run got=%0d want=%0d", vld_run, 2 * DEPTH - 1); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b want=0", o_valid); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL b2b_no_ovf got=%b want=0", o_overflow); end
        tick();
        checks++; if (o_out_vld !== 1'b0) begin failures++; $display("FAIL b2b_vld_end got=%b want=0", o_out_vld); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        wr = 8'hFF;
        for (int r = 1; r <= 6; r++) begin
            in = row_pat(r);
            tick();
        end
        wr = '0; rd = 1'b1;
        tick();
        checks++; if (out !== row_pat(1)) begin failures++; $display("FAIL mid_pre_out got=%h want=%h", out, row_pat(1)); end
        reset = 1'b1;
        tick();
        reset = 1'b0; rd = 1'b0;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b want=0", o_valid); end
        checks++; if (o_out_vld !== 1'b0) begin failures++; $display("FAIL mid_out_vld got=%b want=0", o_out_vld); end
        checks++; if (out !== '0) begin failures++; $display("FAIL mid_out got=%h want=0", out); end
        checks++; if (u_dut.cnt_v !== '0) begin failures++; $display("FAIL mid_cnts got=%h want=0", u_dut.cnt_v); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b want=1", o_ready); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; wr = '0; rd = 1'b0; clr_err = 1'b0; in = '0;
        test_reset();
        test_single_row();
        test_staggered();
        test_full_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
